// File: rtl/mul_seq_pkg.sv
// Shared types and sizing for the shift-and-add multiplier sequencer.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BITS_DEFAULT = 32;

    // Iteration counter width: must hold 0..BITS-1 plus headroom for BITS-count.
    function automatic int cnt_width(input int bits);
        return $clog2(bits) + 1;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(BITS_DEFAULT);

endpackage

// File: rtl/mul_shift_reg.sv
// Accumulator / multiplier-quotient pair {acc,mq} for shift-and-add multiply.
// Build option MUL_EARLY_EXIT_EN adds a one-cycle variable right shift used
// to finish early once the remaining multiplier bits are all zero.
import mul_seq_pkg::*;

module mul_shift_reg #(
    parameter int BITS = BITS_DEFAULT
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              load,
    input  logic [BITS-1:0]   load_mq,
    input  logic              step,
    input  logic [BITS:0]     add_sum,
`ifdef MUL_EARLY_EXIT_EN
    input  logic              shift,
    input  logic [cnt_width(BITS):0] shamt,
`endif
    output logic [BITS-1:0]   acc,
    output logic [BITS-1:0]   mq,
    output logic [BITS-1:0]   acc_nxt,
    output logic [BITS-1:0]   mq_nxt
);

    // Next value: load clears acc, step folds the adder result in and shifts
    // the pair right by one, the adder carry landing in the acc MSB.
    always_comb begin
        acc_nxt = acc;
        mq_nxt  = mq;
        if (load) begin
            acc_nxt = '0;
            mq_nxt  = load_mq;
`ifdef MUL_EARLY_EXIT_EN
        end else if (shift) begin
            {acc_nxt, mq_nxt} = {acc, mq} >> shamt;
`endif
        end else if (step) begin
            acc_nxt = add_sum[BITS:1];
            mq_nxt  = {add_sum[0], mq[BITS-1:1]};
        end
    end

    // Pair register with synchronous clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            acc <= '0;
            mq  <= '0;
        end else begin
            acc <= acc_nxt;
            mq  <= mq_nxt;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle unsigned shift-and-add multiplier controller driving an
// external BITS-wide adder through add_a/add_b/add_sum.
// Optional build macro: MUL_EARLY_EXIT_EN (skip trailing zero multiplier bits).
import mul_seq_pkg::*;

module mul_sequencer #(
    parameter int BITS = BITS_DEFAULT
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              start,
    input  logic [BITS-1:0]   multiplicand,
    input  logic [BITS-1:0]   multiplier,
    output logic [BITS-1:0]   add_a,
    output logic [BITS-1:0]   add_b,
    input  logic [BITS:0]     add_sum,
    output logic              busy,
    output logic              done,
    output logic [2*BITS-1:0] product
);

    localparam int CW = cnt_width(BITS);

    state_t          state, state_nxt;
    logic [BITS-1:0] mcand;
    logic [CW-1:0]   count;
    logic [BITS-1:0] acc, mq, acc_nxt, mq_nxt;
    logic            load, step, skip;

`ifdef MUL_EARLY_EXIT_EN
    logic [BITS-1:0] pend_mask;
    logic [CW:0]     shamt;

    // Unprocessed multiplier bits sit at mq[BITS-1-count:0]; if none are set
    // the remaining iterations would only shift, so collapse them into one.
    always_comb begin
        pend_mask = {BITS{1'b1}} >> count;
        shamt     = (CW+1)'(BITS) - {1'b0, count};
        skip      = (state == RUN) && ((mq & pend_mask) == '0);
    end
`else
    assign skip = 1'b0;
`endif

    mul_shift_reg #(.BITS(BITS)) u_pair (
        .clock   (clock),
        .clear   (clear),
        .load    (load),
        .load_mq (multiplier),
        .step    (step),
        .add_sum (add_sum),
`ifdef MUL_EARLY_EXIT_EN
        .shift   (skip),
        .shamt   (shamt),
`endif
        .acc     (acc),
        .mq      (mq),
        .acc_nxt (acc_nxt),
        .mq_nxt  (mq_nxt)
    );

    // Next-state and adder operand control; adder operands idle at zero.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        add_a     = '0;
        add_b     = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (skip) begin
                    state_nxt = DONE;
                end else begin
                    step  = 1'b1;
                    add_a = acc;
                    add_b = mq[0] ? mcand : '0;
                    if (count == CW'(BITS-1))
                        state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, operand/count and registered outputs; product captured on the
    // edge entering DONE so it appears together with the done pulse.
    always_ff @(posedge clock) begin
        if (clear) begin
            state   <= IDLE;
            mcand   <= '0;
            count   <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= (state == RUN) && (state_nxt == DONE);
            if (load) begin
                mcand   <= multiplicand;
                count   <= '0;
                product <= '0;
            end
            if (step)
                count <= count + CW'(1);
            if ((state == RUN) && (state_nxt == DONE))
                product <= {acc_nxt, mq_nxt};
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a behavioural adder beside it.
module tb_mul_sequencer;

`ifdef MUL_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif
    localparam int BITS = 32;
    localparam int FULL = BITS + 1;

    logic              clock = 1'b0;
    logic              clear;
    logic              start;
    logic [BITS-1:0]   multiplicand, multiplier;
    logic [BITS-1:0]   add_a, add_b;
    logic [BITS:0]     add_sum;
    logic              busy, done;
    logic [2*BITS-1:0] product;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    // The shared adder outside the sequencer.
    assign add_sum = {1'b0, add_a} + {1'b0, add_b};

    mul_sequencer #(.BITS(BITS)) dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_sum      (add_sum),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    typedef struct {
        string         nm;
        logic [31:0]   a;
        logic [31:0]   b;
        logic [63:0]   p;
        int            dc_fix;
        int            dc_ee;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One multiply from the start edge (cycle 0) through the first IDLE cycle.
    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] p, input int dc);
        int ndone, first;
        bit busy_ok;
        ndone = 0; first = -1; busy_ok = 1'b1;
        @(negedge clock);
        start = 1'b1; multiplicand = a; multiplier = b;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= dc + 1; c++) begin
            if (c > 1) @(negedge clock);
            if (done) begin
                ndone++;
                if (first < 0) first = c;
                chk({nm, " product"}, product, p);
            end
            if (c <= dc && !busy) busy_ok = 1'b0;
        end
        chk({nm, " done_cycle"}, 64'(first), 64'(dc));
        chk({nm, " done_count"}, 64'(ndone), 64'd1);
        chk({nm, " busy_during"}, 64'(busy_ok), 64'd1);
        chk({nm, " busy_after"}, 64'(busy), 64'd0);
        chk({nm, " product_hold"}, product, p);
    endtask

    vec_t vecs[7];

    initial begin
        int dc, ndone, first;
        int dcs[$];

        vecs[0] = '{"7x6",      32'd7,          32'd6,          64'd42,                  FULL, 5};
        vecs[1] = '{"ffxff",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, FULL, FULL};
        vecs[2] = '{"123x456",  32'd123,        32'd456,        64'd56088,               FULL, 11};
        vecs[3] = '{"x0",       32'h1234_5678,  32'd0,          64'd0,                   FULL, 2};
        vecs[4] = '{"x1",       32'h1234_5678,  32'd1,          64'h1234_5678,           FULL, 3};
        vecs[5] = '{"xmsb",     32'h1234_5678,  32'h8000_0000,  64'h091A_2B3C_0000_0000, FULL, FULL};
        vecs[6] = '{"msbxmsb",  32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, FULL, FULL};

        clear = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst product", product, 64'd0);
        chk("rst add_a", 64'(add_a), 64'd0);
        chk("rst add_b", 64'(add_b), 64'd0);
        clear = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].p,
                   EE ? vecs[i].dc_ee : vecs[i].dc_fix);

        // start pulsed mid-run must be ignored
        dc = EE ? 19 : FULL;
        ndone = 0; first = -1;
        @(negedge clock);
        start = 1'b1; multiplicand = 32'h1_0000; multiplier = 32'h1_0000;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= dc + 3; c++) begin
            if (c > 1) @(negedge clock);
            if (c == 5) begin start = 1'b1; multiplicand = 32'd3; multiplier = 32'd3; end
            if (c == 6) start = 1'b0;
            if (done) begin
                ndone++;
                if (first < 0) first = c;
                chk("retrig product", product, 64'h1_0000_0000);
            end
        end
        chk("retrig done_cycle", 64'(first), 64'(dc));
        chk("retrig done_count", 64'(ndone), 64'd1);
        chk("retrig product_hold", product, 64'h1_0000_0000);

        // clear at cycle 10 discards the in-flight multiply
        ndone = 0;
        @(negedge clock);
        start = 1'b1; multiplicand = 32'd123; multiplier = 32'd456;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clock);
            if (done) ndone++;
            if (c == 10) clear = 1'b1;
        end
        @(negedge clock);
        clear = 1'b0;
        chk("clr busy", 64'(busy), 64'd0);
        chk("clr product", product, 64'd0);
        chk("clr done", 64'(done), 64'd0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done) ndone++;
        end
        chk("clr no_done", 64'(ndone), 64'd0);
        run_op("post_clr", 32'd123, 32'd456, 64'd56088, EE ? 11 : FULL);

        // start held high: back-to-back re-acceptance
        dc = EE ? 5 : FULL;
        dcs.delete();
        @(negedge clock);
        start = 1'b1; multiplicand = 32'd2; multiplier = 32'd5;
        @(posedge clock);
        for (int c = 1; c <= 3 * dc + 2; c++) begin
            @(negedge clock);
            if (done) begin
                dcs.push_back(c);
                chk("held product", product, 64'd10);
            end
            if (c == 3 * dc + 2) start = 1'b0;
        end
        chk("held done_count", 64'(dcs.size()), 64'd3);
        if (dcs.size() == 3) begin
            chk("held done1", 64'(dcs[0]), 64'(dc));
            chk("held done2", 64'(dcs[1]), 64'(2 * dc + 1));
            chk("held done3", 64'(dcs[2]), 64'(3 * dc + 2));
        end
        repeat (3) @(negedge clock);
        chk("held idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
